// File: rtl/mux_pkg.sv
// Shared widths and types for the 8-to-1 registered bit selector.
package mux_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_IN-1:0]  mux_in_t;

endpackage : mux_pkg

// File: rtl/mux_8x1_comb.sv
// Combinational 8-to-1 bit selector: y = in[sel].
module mux_8x1_comb
  import mux_pkg::*;
(
  input  mux_in_t in,
  input  sel_t    sel,
  output logic    y
);

  // Decode the select code into the chosen input bit.
  always_comb begin
    // NOTE: y gets a value on every path (the default branch included) so no latch is inferred.
    y = 1'b0;
    case (sel)
      3'd0:    y = in[0];
      3'd1:    y = in[1];
      3'd2:    y = in[2];
      3'd3:    y = in[3];
      3'd4:    y = in[4];
      3'd5:    y = in[5];
      3'd6:    y = in[6];
      3'd7:    y = in[7];
      // Only reachable when sel carries X/Z; drive a known 0.
      default: y = 1'b0;
    endcase
  end

endmodule : mux_8x1_comb

// File: rtl/mux_8x1.sv
// 8-to-1 single-bit multiplexer with a registered, glitch-free output.
// The bit selected at edge N appears on out after edge N; there is no
// combinational path from in/sel to out.
module mux_8x1
  import mux_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  mux_in_t in,
  input  sel_t    sel,
  output logic    out
);

  logic out_d;
  logic out_q;

  mux_8x1_comb u_sel (
    .in  (in),
    .sel (sel),
    .y   (out_d)
  );

  // Output register; synchronous active-low reset has priority over selection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_q <= RST_VAL;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : mux_8x1

// File: tb/tb_mux_8x1.sv
// Scoreboard bench for mux_8x1: the driver pushes hand-computed expected
// values, the monitor pops and compares one per clock after each edge.
module tb_mux_8x1;
  import mux_pkg::*;

  typedef struct {
    logic  exp;
    string tag;
  } exp_t;

  logic    clk;
  logic    rst_n;
  mux_in_t in;
  sel_t    sel;
  logic    out;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  mux_8x1 #(.RST_VAL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .sel   (sel),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the value
  // out must show after the following rising edge.
  task automatic step(input mux_in_t i, input sel_t s, input logic r,
                      input logic exp, input string tag);
    exp_t e;
    @(negedge clk);
    in    = i;
    sel   = s;
    rst_n = r;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: one comparison per rising edge while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, out, e.exp);
      end
    end
  end

  initial begin
    exp_t e;
    int   wait_cycles;
    in    = '0;
    sel   = '0;
    rst_n = 1'b0;

    // Reset held two edges with in/sel pointing at a 1, then release.
    step(8'hFF, 3'd5, 1'b0, 1'b0, "reset_edge0");
    step(8'hFF, 3'd5, 1'b0, 1'b0, "reset_edge1");
    step(8'hFF, 3'd5, 1'b1, 1'b1, "reset_release");

    // One-hot walk: selected bit is always the single set bit.
    for (int k = 0; k < 8; k++)
      step(mux_in_t'(1 << k), sel_t'(k), 1'b1, 1'b1, $sformatf("onehot_%0d", k));

    // Mismatch walk: selected bit is always the neighbour of the set bit.
    for (int k = 0; k < 8; k++)
      step(mux_in_t'(1 << k), sel_t'((k + 1) % 8), 1'b1, 1'b0, $sformatf("mismatch_%0d", k));

    // Unselected-bit isolation on sel = 3.
    step(8'b0000_1000, 3'd3, 1'b1, 1'b1, "iso_base");
    step(8'b1111_1111, 3'd3, 1'b1, 1'b1, "iso_others_high");
    step(8'b0000_1000, 3'd3, 1'b1, 1'b1, "iso_others_low");
    step(8'b1111_0111, 3'd3, 1'b1, 1'b0, "iso_sel_low");

    // Latency: sel 0 -> 7 with in = 8'h80; out must hold old in[0] until the edge.
    step(8'b1000_0000, 3'd0, 1'b1, 1'b0, "lat_sel0");
    @(negedge clk);
    sel = 3'd7;
    #1;
    check("lat_before_edge", out, 1'b0);
    e.exp = 1'b1;
    e.tag = "lat_after_edge";
    sb_q.push_back(e);

    // Mid-run reset pulse.
    step(8'hFF, 3'd2, 1'b1, 1'b1, "mid_pre");
    step(8'hFF, 3'd2, 1'b0, 1'b0, "mid_reset");
    step(8'hFF, 3'd2, 1'b1, 1'b1, "mid_release");

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_8x1
